// File: rtl/mac_driver_pkg.sv
// Shared types and default parameters for the mac_driver sequencer.
package mac_driver_pkg;

    localparam int W_DEF        = 14;
    localparam int ACC_W_DEF    = 28;
    localparam int VEC_LEN_DEF  = 8;
    localparam int LATENCY_DEF  = 8;
    localparam int CLR_WAIT_DEF = 8;

    typedef enum logic [2:0] {
        CLEAR,
        WAIT_CLR,
        FEED,
        DRAIN,
        HOLD
    } state_t;

    // Bits needed to hold values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mac_driver_ctrl.sv
// Sequencing FSM for mac_driver: beat/pulse counters, clear wait, optional DRAIN
// watchdog (enabled by defining MAC_DRIVER_WATCHDOG_EN).
//
// state    | meaning
// CLEAR    | mac_clr high for one cycle, counters zeroed
// WAIT_CLR | let the MAC come out of its internal reset
// FEED     | accept VEC_LEN operand pairs
// DRAIN    | wait for the MAC's last valid_out pulse
// HOLD     | result presented until m_ready
module mac_driver_ctrl
    import mac_driver_pkg::*;
#(
    parameter int VEC_LEN  = VEC_LEN_DEF,
    parameter int LATENCY  = LATENCY_DEF,
    parameter int CLR_WAIT = CLR_WAIT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic s_valid,
    input  logic mac_valid_out,
    input  logic m_ready,
    output logic s_ready,
    output logic mac_clr,
    output logic m_valid,
    output logic load,
    output logic capture,
    output logic err
);

    localparam int CNT_W  = cnt_width(VEC_LEN);
    localparam int WAIT_W = cnt_width(CLR_WAIT);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(VEC_LEN - 1);
    localparam logic [CNT_W-1:0]  FULL      = CNT_W'(VEC_LEN);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'((CLR_WAIT > 0) ? CLR_WAIT - 1 : 0);

    state_t state, state_nxt;
    logic [CNT_W-1:0]  in_cnt, out_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic pulse_last, wd_expired;

    assign pulse_last = mac_valid_out && (out_cnt == LAST_BEAT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= CLEAR;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:    state_nxt = (CLR_WAIT == 0) ? FEED : WAIT_CLR;
            WAIT_CLR: if (wait_cnt == '0) state_nxt = FEED;
            FEED:     if (s_valid && in_cnt == LAST_BEAT) state_nxt = DRAIN;
            DRAIN:    if (pulse_last || wd_expired) state_nxt = HOLD;
            HOLD:     if (m_ready) state_nxt = CLEAR;
            default:  state_nxt = CLEAR;
        endcase
    end

    always_comb begin
        s_ready = (state == FEED);
        mac_clr = (state == CLEAR);
        m_valid = (state == HOLD);
        load    = s_ready && s_valid;
        capture = (state == DRAIN) && (pulse_last || wd_expired);
    end

    // Pulses outside FEED/DRAIN belong to no vector; out_cnt saturates at VEC_LEN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_cnt   <= '0;
            out_cnt  <= '0;
            wait_cnt <= '0;
        end else if (state == CLEAR) begin
            in_cnt   <= '0;
            out_cnt  <= '0;
            wait_cnt <= WAIT_LOAD;
        end else begin
            if (state == WAIT_CLR && wait_cnt != '0)
                wait_cnt <= wait_cnt - 1'b1;
            if (load)
                in_cnt <= in_cnt + 1'b1;
            if (mac_valid_out && (state == FEED || state == DRAIN) && out_cnt != FULL)
                out_cnt <= out_cnt + 1'b1;
        end
    end

`ifdef MAC_DRIVER_WATCHDOG_EN
    localparam int WD_W = cnt_width(LATENCY + 1);
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(LATENCY + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            err_q;

    // Reloaded on DRAIN entry and on every MAC pulse; terminal count means the
    // MAC has been silent for LATENCY+2 DRAIN cycles.
    assign wd_expired = (state == DRAIN) && !mac_valid_out && (wd_cnt == '0);
    assign err        = err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt <= WD_LOAD;
            err_q  <= 1'b0;
        end else begin
            if (state != DRAIN || mac_valid_out)
                wd_cnt <= WD_LOAD;
            else if (wd_cnt != '0)
                wd_cnt <= wd_cnt - 1'b1;
            if (wd_expired)
                err_q <= 1'b1;
        end
    end
`else
    assign wd_expired = 1'b0;
    assign err        = 1'b0;
`endif

endmodule

// File: rtl/mac_driver.sv
// Initiator-side sequencer for the pipelined saturating MAC: operand and result
// registers around mac_driver_ctrl. Watchdog selected by MAC_DRIVER_WATCHDOG_EN.
module mac_driver
    import mac_driver_pkg::*;
#(
    parameter int W        = W_DEF,
    parameter int ACC_W    = ACC_W_DEF,
    parameter int VEC_LEN  = VEC_LEN_DEF,
    parameter int LATENCY  = LATENCY_DEF,
    parameter int CLR_WAIT = CLR_WAIT_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic signed [W-1:0]     s_a,
    input  logic signed [W-1:0]     s_b,
    output logic signed [W-1:0]     mac_a,
    output logic signed [W-1:0]     mac_b,
    output logic                    mac_valid_in,
    output logic                    mac_clr,
    input  logic signed [ACC_W-1:0] mac_f,
    input  logic                    mac_valid_out,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic signed [ACC_W-1:0] m_data,
    output logic                    err
);

    logic load, capture;

    mac_driver_ctrl #(
        .VEC_LEN  (VEC_LEN),
        .LATENCY  (LATENCY),
        .CLR_WAIT (CLR_WAIT)
    ) u_ctrl (
        .clk           (clk),
        .reset         (reset),
        .s_valid       (s_valid),
        .mac_valid_out (mac_valid_out),
        .m_ready       (m_ready),
        .s_ready       (s_ready),
        .mac_clr       (mac_clr),
        .m_valid       (m_valid),
        .load          (load),
        .capture       (capture),
        .err           (err)
    );

    // Operands hold their last value across gaps; m_data is mac_f verbatim.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mac_a        <= '0;
            mac_b        <= '0;
            mac_valid_in <= 1'b0;
            m_data       <= '0;
        end else begin
            mac_valid_in <= load;
            if (load) begin
                mac_a <= s_a;
                mac_b <= s_b;
            end
            if (capture)
                m_data <= mac_f;
        end
    end

endmodule

// File: tb/tb_mac_driver.sv
// Self-checking bench for mac_driver with a behavioural saturating MAC model.
module tb_mac_driver;

    localparam int W  = 14;
    localparam int AW = 28;
    localparam int VL = 4;
    localparam int L  = 8;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic reset;
    logic s_valid, s_ready, m_ready, m_valid, mac_valid_in, mac_clr, mac_valid_out, err;
    logic signed [W-1:0]  s_a, s_b, mac_a, mac_b;
    logic signed [AW-1:0] mac_f, m_data;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    mac_driver #(.W(W), .ACC_W(AW), .VEC_LEN(VL), .LATENCY(L), .CLR_WAIT(CW)) dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
        .s_a(s_a), .s_b(s_b), .mac_a(mac_a), .mac_b(mac_b),
        .mac_valid_in(mac_valid_in), .mac_clr(mac_clr), .mac_f(mac_f),
        .mac_valid_out(mac_valid_out), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .err(err)
    );

    // Behavioural MAC: product enters at valid_in, accumulates at the last stage.
    bit stub = 1'b0;
    logic                 pv [L-1];
    logic signed [AW-1:0] pp [L-1];
    logic                 out_v;
    logic signed [AW-1:0] acc;

    function automatic logic signed [AW-1:0] prod(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
        logic signed [AW-1:0] ea, eb;
        ea = a;
        eb = b;
        return ea * eb;
    endfunction

    function automatic logic signed [AW-1:0] sat_add(input logic signed [AW-1:0] a, input logic signed [AW-1:0] b);
        logic signed [AW:0] s;
        s = a + b;
        if (s > 29'sd134217727)       return 28'sh7FFFFFF;
        else if (s < -29'sd134217728) return 28'sh8000000;
        else                          return s[AW-1:0];
    endfunction

    always @(posedge clk) begin
        if (mac_clr) begin
            for (int i = 0; i < L-1; i++) begin
                pv[i] <= 1'b0;
                pp[i] <= '0;
            end
            out_v <= 1'b0;
            acc   <= '0;
        end else begin
            pv[0] <= mac_valid_in;
            pp[0] <= prod(mac_a, mac_b);
            for (int i = 1; i < L-1; i++) begin
                pv[i] <= pv[i-1];
                pp[i] <= pp[i-1];
            end
            out_v <= pv[L-2] && !stub;
            if (pv[L-2] && !stub) acc <= sat_add(acc, pp[L-2]);
        end
    end
    assign mac_valid_out = out_v;
    assign mac_f         = acc;

    typedef struct {
        logic [3:0][W-1:0] a;
        logic [3:0][W-1:0] b;
        bit                gaps;
        bit                hold;
        bit                early;
        logic signed [AW-1:0] expv;
    } vec_t;

    vec_t tbl [5];
    vec_t v23;
    logic signed [AW-1:0] sb [$];
    int n_checks = 0;
    int n_err = 0;

    function automatic logic [3:0][W-1:0] mk(input int x0, input int x1, input int x2, input int x3);
        logic [3:0][W-1:0] r;
        r[0] = W'(x0); r[1] = W'(x1); r[2] = W'(x2); r[3] = W'(x3);
        return r;
    endfunction

    task automatic chk(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_s_ready"}, s_ready, 0);
        chk({tag, "_mac_a"}, mac_a, 0);
        chk({tag, "_mac_b"}, mac_b, 0);
        chk({tag, "_mac_valid_in"}, mac_valid_in, 0);
        chk({tag, "_mac_clr"}, mac_clr, 1);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_m_data"}, m_data, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    task automatic wait_ready();
        int guard = 0;
        while (!s_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!s_ready) chk("s_ready_timeout", s_ready, 1);
    endtask

    task automatic beat(input logic [W-1:0] a, input logic [W-1:0] b);
        s_valid = 1'b1;
        s_a = a;
        s_b = b;
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
        chk("beat_mac_valid_in", mac_valid_in, 1);
        chk("beat_mac_a", mac_a, $signed(a));
        chk("beat_mac_b", mac_b, $signed(b));
    endtask

    task automatic drive_vec(input vec_t v, output int t_last);
        wait_ready();
        for (int i = 0; i < VL; i++) begin
            beat(v.a[i], v.b[i]);
            t_last = cyc;
            if (v.gaps && i < VL-1) begin
                @(negedge clk);
                chk("gap_mac_valid_in", mac_valid_in, 0);
                chk("gap_mac_a_held", mac_a, $signed(v.a[i]));
            end
        end
    endtask

    task automatic get_result(input int t_last, input bit hold, input bit early);
        int guard = 0;
        logic signed [AW-1:0] e;
        while (!m_valid && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        e = sb.pop_front();
        if (!m_valid) begin
            chk("m_valid_timeout", m_valid, 1);
            return;
        end
        chk("m_data", m_data, e);
        chk("result_latency", cyc - t_last, L + 1);
        if (!early) begin
            if (hold) begin
                repeat (10) begin
                    @(negedge clk);
                    chk("hold_m_valid", m_valid, 1);
                    chk("hold_m_data", m_data, e);
                    chk("hold_s_ready", s_ready, 0);
                    chk("hold_mac_clr", mac_clr, 0);
                end
            end
            m_ready = 1'b1;
        end
        @(negedge clk);
        chk("post_hs_m_valid", m_valid, 0);
        chk("post_hs_mac_clr", mac_clr, 1);
        m_ready = 1'b0;
    endtask

    initial begin
        int t;
        int guard;

        tbl[0] = '{mk(3, 3, 3, 3), mk(5, 5, 5, 5), 1'b0, 1'b1, 1'b0, 28'sd60};
        tbl[1] = '{mk(8191, 8191, 8191, 8191), mk(8191, 8191, 8191, 8191), 1'b0, 1'b0, 1'b0, 28'sd134217727};
        tbl[2] = '{mk(-8192, -8192, -8192, -8192), mk(8191, 8191, 8191, 8191), 1'b0, 1'b0, 1'b0, -28'sd134217728};
        tbl[3] = '{mk(1, 2, -3, 5), mk(1, 2, 4, -1), 1'b1, 1'b0, 1'b0, -28'sd12};
        tbl[4] = '{mk(-1, 100, 13, 0), mk(7, -100, 13, 5), 1'b0, 1'b0, 1'b1, -28'sd9838};
        v23    = '{mk(2, 2, 2, 2), mk(3, 3, 3, 3), 1'b0, 1'b0, 1'b0, 28'sd24};

        reset = 1'b0;
        s_valid = 1'b0;
        s_a = '0;
        s_b = '0;
        m_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        reset = 1'b1;

        for (int i = 0; i < 5; i++) begin
            m_ready = tbl[i].early;
            sb.push_back(tbl[i].expv);
            drive_vec(tbl[i], t);
            get_result(t, tbl[i].hold, tbl[i].early);
        end

        // Reset in the middle of FEED discards the partial vector.
        wait_ready();
        beat(14'(2), 14'(3));
        beat(14'(2), 14'(3));
        #2 reset = 1'b0;
        #1 chk_reset_vals("midfeed");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        sb.push_back(v23.expv);
        drive_vec(v23, t);
        get_result(t, 1'b0, 1'b0);

        // Silent MAC: DRAIN never sees a pulse.
        stub = 1'b1;
        drive_vec(v23, t);
`ifdef MAC_DRIVER_WATCHDOG_EN
        guard = 0;
        while (!m_valid && guard < 100) begin
            chk("wd_err_early", err, 0);
            @(negedge clk);
            guard++;
        end
        chk("wd_m_valid", m_valid, 1);
        chk("wd_latency", cyc - t, L + 2);
        chk("wd_err", err, 1);
        chk("wd_m_data", m_data, 0);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        chk("wd_err_sticky", err, 1);
        chk("wd_mac_clr", mac_clr, 1);
`else
        guard = 0;
        repeat (40) @(negedge clk);
        chk("nowd_m_valid", m_valid, 0);
        chk("nowd_err", err, 0);
        chk("nowd_s_ready", s_ready, 0);
        chk("nowd_m_data", m_data, 24);
`endif
        stub = 1'b0;
        #2 reset = 1'b0;
        #1 chk_reset_vals("final");
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
